fetch_sequencer: RTL
====================

# fetch_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch. It issues one outstanding request at a time to instruction memory over a valid/ready handshake and buffers one returned instruction for decode. It applies trap and branch/jump redirects with fixed priority and drops stale responses after a redirect.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap_valid
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- trap_valid  in  1  trap redirect request (highest priority)
- redirect_valid  in  1  branch/jump taken, from execute
- redirect_pc  in  32  branch/jump target
- stall  in  1  decode cannot accept the instruction this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address; equals pc
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  instruction word returned
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  inst/inst_pc hold a valid instruction for decode
- inst  out  32  buffered instruction
- inst_pc  out  32  address of inst
- pc  out  32  current fetch PC
- misalign_exc  out  1  misaligned redirect target detected (FETCH_MISALIGN_TRAP_EN only; tied 0 otherwise)

## Operation
- States: BOOT, REQ, WAIT, DISCARD.
- BOOT is entered on reset. It lasts one cycle after reset_n deasserts, then goes to REQ.
- REQ: imem_req_valid=1. On valid&ready, capture the in-flight address and go to WAIT.
- Gate in REQ: REQ asserts imem_req_valid only while the output buffer is empty, or is being consumed (inst_valid&!stall) this cycle. Otherwise imem_req_valid=0 and the block stays in REQ.
- WAIT: on imem_rsp_valid, load inst<=imem_rsp_data and inst_pc<=captured address, set inst_valid=1, set pc<=pc+4 (mod 2^32), then go to REQ.
- Consumption: inst_valid&!stall in a cycle with no new response clears inst_valid next cycle.
- Redirect target selection: trap_valid uses TRAP_VECTOR, else redirect_pc. Same-cycle trap and redirect: trap wins.
- Redirect effects: pc<=target and inst_valid<=0 next cycle, whatever the state or stall.
- Redirect in WAIT, or in REQ with a handshake in the same cycle: go to DISCARD.
- Redirect in REQ with no handshake: stay in REQ with the new address. The address may change while valid&!ready.
- Redirect in BOOT: takes effect, and the block goes to REQ.
- DISCARD: drop the next imem_rsp_valid with no buffer update, then go to REQ. A further redirect while in DISCARD updates pc only.
- Response arriving in a state other than WAIT or DISCARD: protocol error, ignored.

## Timing
- Reset values: pc=RESET_VECTOR, imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, misalign_exc=0, state=BOOT.
- First request: imem_req_valid=1 in the 2nd cycle after reset_n deasserts.
- Fetch latency: response captured in cycle N gives inst_valid=1 in N+1. With a zero-wait memory (ready=1, response the cycle after acceptance), throughput is one instruction per 2 cycles.
- Redirect latency: redirect sampled in cycle N gives pc=target and imem_req_addr=target in N+1. The first request to the target is issued in N+1, or in N+2 if a stale response is still pending.
- Reset asserted mid-operation returns all state to reset values immediately. An outstanding memory response after reset is ignored.
- All outputs are registered except imem_req_valid, which is combinational from the state and buffer occupancy.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect_pc with [1:0]!=0 is not applied. The block instead asserts misalign_exc for one cycle and loads pc<=TRAP_VECTOR.
  - Stale-response handling is the same as for a trap.
  - trap_valid targets are never checked.
- FETCH_MISALIGN_TRAP_EN undefined: redirect_pc[1:0] is forced to 2'b00, and misalign_exc is constant 0.

## Test plan
- Reset release, ready=1, 1-cycle memory returning addr-tagged words: imem_req_addr goes 0x0, 0x4, 0x8. inst_pc/inst pairs match, and pc wraps from 0xFFFF_FFFC to 0x0.
- stall=1 held 5 cycles with inst_valid=1: inst stays stable, imem_req_valid=0. Releasing stall gives the next request in the same cycle.
- redirect_valid with redirect_pc=0x200 while in WAIT: the stale response is dropped (inst_valid stays 0), then the next request is to 0x200 and inst_pc=0x200.
- trap_valid and redirect_valid (0x300) in the same cycle: pc=0x100 next cycle, and no fetch to 0x300.
- reset_n pulsed low while in WAIT: pc=0, inst_valid=0 immediately, and the late response is ignored.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x202: misalign_exc pulses for 1 cycle and the next fetch is 0x100. Without the macro, the next fetch is 0x200.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one outstanding imem request, buffers one instruction.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect targets trap instead of being truncated).
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        trap_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] pc,
    output logic        misalign_exc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic            inst_valid_q;
    logic            misalign_q;

    logic            handshake_c;
    logic            consume_c;
    logic            redir_c;
    logic            misalign_c;
    logic [XLEN-1:0] target_c;

    // Request only when the buffer is free now or is being drained this cycle.
    assign imem_req_valid = (state_q == ST_REQ) && (!inst_valid_q || !stall);
    assign handshake_c    = imem_req_valid && imem_req_ready;
    assign consume_c      = inst_valid_q && !stall;
    assign redir_c        = trap_valid || redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_c = redirect_valid && !trap_valid && (redirect_pc[1:0] != 2'b00);
    assign target_c   = (trap_valid || misalign_c) ? TRAP_VECTOR : redirect_pc;
`else
    assign misalign_c = 1'b0;
    assign target_c   = trap_valid ? TRAP_VECTOR : (redirect_pc & 32'hFFFF_FFFC);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            addr_q       <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            misalign_q <= misalign_c;
            if (consume_c) begin
                inst_valid_q <= 1'b0;
            end
            if (redir_c) begin
                pc_q         <= target_c;
                inst_valid_q <= 1'b0;
            end
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_REQ;
                end
                ST_REQ: begin
                    if (redir_c) begin
                        state_q <= handshake_c ? ST_DISCARD : ST_REQ;
                    end else if (handshake_c) begin
                        addr_q  <= pc_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response coinciding with the redirect is the stale one; nothing left to drop.
                    if (redir_c) begin
                        state_q <= imem_rsp_valid ? ST_REQ : ST_DISCARD;
                    end else if (imem_rsp_valid) begin
                        inst_q       <= imem_rsp_data;
                        inst_pc_q    <= addr_q;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_q + 32'd4;
                        state_q      <= ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (imem_rsp_valid) begin
                        state_q <= ST_REQ;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req_addr = pc_q;
    assign pc            = pc_q;
    assign inst          = inst_q;
    assign inst_pc       = inst_pc_q;
    assign inst_valid    = inst_valid_q;
    assign misalign_exc  = misalign_q;

endmodule
